// File: rtl/game_ctrl.sv
// Breakout game sequencer: owns the game FSM, lives, level, score,
// and drives the ball datapath reset pulse and run enable.
module game_ctrl #(
    parameter int unsigned DELAY_FRAMES = 120,
    parameter logic [1:0]  START_LIVES  = 2'd3,
    parameter logic [7:0]  KEY_START    = 8'h28,
    parameter logic [7:0]  KEY_SERVE    = 8'h2C,
    parameter logic [7:0]  KEY_PAUSE    = 8'h13
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [7:0]  keycode,
    input  logic [31:0] Blocks,
    input  logic        Bar_Reset,
    output logic        Ball_Rst,
    output logic        Run,
    output logic [32:0] Block_Array,
    output logic [2:0]  state,
    output logic [1:0]  lives,
    output logic [1:0]  level,
    output logic [15:0] score
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_LOST  = 3'd4;
    localparam logic [2:0] S_CLEAR = 3'd5;
    localparam logic [2:0] S_OVER  = 3'd6;

    localparam logic [15:0] CNT_LAST = 16'(DELAY_FRAMES - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [1:0]  level_q, level_d;
    logic [15:0] score_q, score_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] prev_blocks_q;
    logic [7:0]  key_q;
    logic        ball_rst_q, ball_rst_d;

    logic        ev_start, ev_serve, ev_pause;
    logic [5:0]  gain;
    logic [16:0] sum;

    function automatic logic [5:0] popcnt(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
        return c;
    endfunction

    // Key events fire only on the frame a key code first appears.
    always_comb begin
        ev_start = (keycode == KEY_START) && (key_q != KEY_START);
        ev_serve = (keycode == KEY_SERVE) && (key_q != KEY_SERVE);
        ev_pause = (keycode == KEY_PAUSE) && (key_q != KEY_PAUSE);
    end

    // Bricks that vanished since last frame, added with saturation.
    always_comb begin
        gain = popcnt(prev_blocks_q & ~Blocks);
        sum  = {1'b0, score_q} + {11'd0, gain};
    end

    // Game FSM with lives, level, score and delay counter next-state.
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        score_d    = score_q;
        cnt_d      = cnt_q;
        ball_rst_d = 1'b0;
        if (state_q == S_PLAY) score_d = sum[16] ? 16'hFFFF : sum[15:0];
        case (state_q)
            S_IDLE, S_OVER: begin
                if (ev_start) begin
                    score_d    = '0;
                    level_d    = '0;
                    lives_d    = START_LIVES;
                    ball_rst_d = 1'b1;
                    state_d    = S_SERVE;
                end
            end
            S_SERVE: if (ev_serve) state_d = S_PLAY;
            S_PLAY: begin
                if (Blocks == 32'd0) begin
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end else if (Bar_Reset) begin
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = S_OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        cnt_d   = '0;
                        state_d = S_LOST;
                    end
                end else if (ev_pause) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: if (ev_pause) state_d = S_PLAY;
            S_LOST: begin
                if (cnt_q == CNT_LAST) state_d = S_SERVE;
                else cnt_d = cnt_q + 16'd1;
            end
            S_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    level_d    = level_q + 2'd1;
                    ball_rst_d = 1'b1;
                    state_d    = S_SERVE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset holds the datapath in reset.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            lives_q       <= START_LIVES;
            level_q       <= '0;
            score_q       <= '0;
            cnt_q         <= '0;
            prev_blocks_q <= '0;
            key_q         <= '0;
            ball_rst_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            score_q       <= score_d;
            cnt_q         <= cnt_d;
            prev_blocks_q <= Blocks;
            key_q         <= keycode;
            ball_rst_q    <= ball_rst_d;
        end
    end

    // Brick pattern decoded from the registered level.
    always_comb begin
        case (level_q)
            2'd0:    Block_Array = {1'b0, 32'hFFFF_FFFF};
            2'd1:    Block_Array = {1'b0, 32'h55AA_55AA};
            2'd2:    Block_Array = {1'b0, 32'hFF81_81FF};
            default: Block_Array = {1'b0, 32'hF0F0_0F0F};
        endcase
    end

    // Output mapping; Run follows the registered state.
    always_comb begin
        Run      = (state_q == S_SERVE) || (state_q == S_PLAY);
        Ball_Rst = ball_rst_q;
        state    = state_q;
        lives    = lives_q;
        level    = level_q;
        score    = score_q;
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: scenario tasks queue expected snapshots
// as stimulus is applied and compare them after each frame edge.
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        Reset;
    logic [7:0]  keycode;
    logic [31:0] Blocks;
    logic        Bar_Reset;
    logic        Ball_Rst, Run;
    logic [32:0] Block_Array;
    logic [2:0]  state;
    logic [1:0]  lives, level;
    logic [15:0] score;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]  st;
        logic        run;
        logic        brst;
        logic [1:0]  lv;
        logic [1:0]  lvl;
        logic [15:0] sc;
        logic [32:0] ba;
    } snap_t;

    snap_t exp_q[$];
    snap_t e, o;

    game_ctrl dut (
        .frame_clk(clk), .Reset(Reset), .keycode(keycode),
        .Blocks(Blocks), .Bar_Reset(Bar_Reset), .Ball_Rst(Ball_Rst),
        .Run(Run), .Block_Array(Block_Array), .state(state),
        .lives(lives), .level(level), .score(score)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] pat(input logic [1:0] l);
        logic [32:0] t [4];
        t[0] = 33'h0_FFFF_FFFF;
        t[1] = 33'h0_55AA_55AA;
        t[2] = 33'h0_FF81_81FF;
        t[3] = 33'h0_F0F0_0F0F;
        return t[l];
    endfunction

    function automatic snap_t mk(input logic [2:0] st, input logic brst,
                                 input logic [1:0] lv, input logic [1:0] lvl,
                                 input logic [15:0] sc);
        snap_t s;
        s.st = st; s.brst = brst; s.lv = lv; s.lvl = lvl; s.sc = sc;
        s.run = (st == 3'd1) || (st == 3'd2);
        s.ba = pat(lvl);
        return s;
    endfunction

    function automatic snap_t obs();
        snap_t s;
        s.st = state; s.run = Run; s.brst = Ball_Rst; s.lv = lives;
        s.lvl = level; s.sc = score; s.ba = Block_Array;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model state kept by the bench.
    logic [1:0]  m_lv, m_lvl;
    logic [15:0] m_sc;

    task automatic test_reset();
        Reset = 1; keycode = 0; Blocks = 32'hFFFF_FFFF; Bar_Reset = 0;
        tick();
        exp_q.push_back(mk(3'd0, 1'b1, 2'd3, 2'd0, 16'd0));
        tick();
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL reset got=%h want=%h", o, e); end
        Reset = 0;
        exp_q.push_back(mk(3'd0, 1'b0, 2'd3, 2'd0, 16'd0));
        tick();
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_release got=%h want=%h", o, e); end
    endtask

    task automatic test_start();
        keycode = 8'h28;
        exp_q.push_back(mk(3'd1, 1'b1, 2'd3, 2'd0, 16'd0));
        tick();
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL start got=%h want=%h", o, e); end
        exp_q.push_back(mk(3'd1, 1'b0, 2'd3, 2'd0, 16'd0));
        tick();
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL start_pulse_width got=%h want=%h", o, e); end
        keycode = 0;
        tick();
        m_lv = 2'd3; m_lvl = 2'd0; m_sc = 16'd0;
    endtask

    task automatic test_held_key();
        keycode = 8'h2C;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(mk(3'd2, 1'b0, m_lv, m_lvl, m_sc));
            tick();
            e = exp_q.pop_front(); o = obs(); total++;
            if (o !== e) begin bad++; $display("FAIL held_serve[%0d] got=%h want=%h", i, o, e); end
        end
        keycode = 8'h13;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk(3'd3, 1'b0, m_lv, m_lvl, m_sc));
            tick();
            e = exp_q.pop_front(); o = obs(); total++;
            if (o !== e) begin bad++; $display("FAIL held_pause[%0d] got=%h want=%h", i, o, e); end
        end
        keycode = 0;
        tick();
        keycode = 8'h13;
        exp_q.push_back(mk(3'd2, 1'b0, m_lv, m_lvl, m_sc));
        tick();
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL unpause got=%h want=%h", o, e); end
        keycode = 0;
        tick();
    endtask

    task automatic test_score();
        Blocks = 32'hFFFF_FFFC; m_sc = 16'd2;
        exp_q.push_back(mk(3'd2, 1'b0, m_lv, m_lvl, m_sc));
        tick();
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL score_2 got=%h want=%h", o, e); end
        Blocks = 32'hFFFF_FFF0; m_sc = 16'd4;
        exp_q.push_back(mk(3'd2, 1'b0, m_lv, m_lvl, m_sc));
        tick();
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL score_4 got=%h want=%h", o, e); end
        keycode = 8'h13;
        tick();
        keycode = 0;
        tick();
        Blocks = 32'hFFFF_FF00;
        exp_q.push_back(mk(3'd3, 1'b0, m_lv, m_lvl, m_sc));
        tick();
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL score_paused got=%h want=%h", o, e); end
        tick();
        keycode = 8'h13;
        exp_q.push_back(mk(3'd2, 1'b0, m_lv, m_lvl, m_sc));
        tick();
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL score_resume got=%h want=%h", o, e); end
        keycode = 0;
        tick();
    endtask

    task automatic test_life_lost();
        for (int life = 0; life < 2; life++) begin
            Bar_Reset = 1;
            keycode = (life == 0) ? 8'h13 : 8'h00;
            m_lv = m_lv - 2'd1;
            exp_q.push_back(mk(3'd4, 1'b0, m_lv, m_lvl, m_sc));
            tick();
            Bar_Reset = 0; keycode = 0;
            e = exp_q.pop_front(); o = obs(); total++;
            if (o !== e) begin bad++; $display("FAIL life_lost[%0d] got=%h want=%h", life, o, e); end
            for (int i = 1; i < 120; i++) begin
                exp_q.push_back(mk(3'd4, 1'b0, m_lv, m_lvl, m_sc));
                tick();
                e = exp_q.pop_front(); o = obs(); total++;
                if (o !== e) begin bad++; $display("FAIL lost_delay[%0d] got=%h want=%h", i, o, e); end
            end
            exp_q.push_back(mk(3'd1, 1'b0, m_lv, m_lvl, m_sc));
            tick();
            e = exp_q.pop_front(); o = obs(); total++;
            if (o !== e) begin bad++; $display("FAIL lost_to_serve got=%h want=%h", o, e); end
            keycode = 8'h2C;
            tick();
            keycode = 0;
            tick();
        end
        Bar_Reset = 1; m_lv = 2'd0;
        exp_q.push_back(mk(3'd6, 1'b0, m_lv, m_lvl, m_sc));
        tick();
        Bar_Reset = 0;
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL game_over got=%h want=%h", o, e); end
        keycode = 8'h28; Blocks = 32'hFFFF_FFFF;
        m_lv = 2'd3; m_lvl = 2'd0; m_sc = 16'd0;
        exp_q.push_back(mk(3'd1, 1'b1, m_lv, m_lvl, m_sc));
        tick();
        keycode = 0;
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL restart got=%h want=%h", o, e); end
        tick();
    endtask

    task automatic test_level_clear();
        logic [15:0] gains [4];
        gains[0] = 16'd32; gains[1] = 16'd16; gains[2] = 16'd20; gains[3] = 16'd16;
        for (int l = 0; l < 4; l++) begin
            keycode = 8'h2C;
            tick();
            keycode = 0;
            tick();
            Blocks = 32'd0;
            Bar_Reset = (l == 0);
            m_sc = m_sc + gains[l];
            exp_q.push_back(mk(3'd5, 1'b0, m_lv, m_lvl, m_sc));
            tick();
            Bar_Reset = 0;
            e = exp_q.pop_front(); o = obs(); total++;
            if (o !== e) begin bad++; $display("FAIL clear_enter[%0d] got=%h want=%h", l, o, e); end
            for (int i = 1; i < 120; i++) begin
                exp_q.push_back(mk(3'd5, 1'b0, m_lv, m_lvl, m_sc));
                tick();
                e = exp_q.pop_front(); o = obs(); total++;
                if (o !== e) begin bad++; $display("FAIL clear_delay[%0d] got=%h want=%h", i, o, e); end
            end
            m_lvl = m_lvl + 2'd1;
            exp_q.push_back(mk(3'd1, 1'b1, m_lv, m_lvl, m_sc));
            tick();
            e = exp_q.pop_front(); o = obs(); total++;
            if (o !== e) begin bad++; $display("FAIL clear_next[%0d] got=%h want=%h", l, o, e); end
            Blocks = pat(m_lvl)[31:0];
            tick();
        end
    endtask

    task automatic test_reset_mid_delay();
        keycode = 8'h2C;
        tick();
        keycode = 0;
        tick();
        Blocks = 32'd0;
        tick();
        for (int i = 1; i < 60; i++) tick();
        Reset = 1;
        exp_q.push_back(mk(3'd0, 1'b1, 2'd3, 2'd0, 16'd0));
        tick();
        Reset = 0;
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL reset_mid_delay got=%h want=%h", o, e); end
        for (int i = 0; i < 130; i++) tick();
        exp_q.push_back(mk(3'd0, 1'b0, 2'd3, 2'd0, 16'd0));
        tick();
        e = exp_q.pop_front(); o = obs(); total++;
        if (o !== e) begin bad++; $display("FAIL no_late_level got=%h want=%h", o, e); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_held_key();
        test_score();
        test_life_lost();
        test_level_clear();
        test_reset_mid_delay();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
